fetch_unit: RTL and testbench

Parametrised superscalar fetch stage. It owns the PC register and issues a FETCH_WIDTH-wide group per cycle to instruction memory and the BTB. It truncates each group at the first predicted-taken slot and buffers fetched instructions in a circular fetch queue. It drains up to DECODE_WIDTH instructions per cycle to decode under a valid/ready handshake, and flushes on a back-end redirect.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 41 ++++
 rtl/fetch_unit_queue.sv | 65 ++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared defaults and the fetch-queue entry layout for the superscalar fetch stage.
package fetch_unit_pkg;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_FETCH_WIDTH  = 2;
    localparam int DEF_DECODE_WIDTH = 2;
    localparam int DEF_FQ_DEPTH     = 8;
    localparam logic [DEF_ADDR_WIDTH-1:0] DEF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] instr;
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic                      pred_taken;
        logic [DEF_ADDR_WIDTH-1:0] pred_target;
    } fetch_entry_t;

    function automatic int entry_width(input int aw, input int dw);
        return dw + 2 * aw + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the imem/BTB request, back-end redirect and decode handshake of the fetch stage.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FETCH_WIDTH  = DEF_FETCH_WIDTH,
    parameter int DECODE_WIDTH = DEF_DECODE_WIDTH,
    parameter int FQ_DEPTH     = DEF_FQ_DEPTH
) ();

    logic [ADDR_WIDTH-1:0]              imem_addr;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0]  imem_data;
    logic [ADDR_WIDTH-1:0]              btb_pc;
    logic [FETCH_WIDTH-1:0]             btb_taken;
    logic [FETCH_WIDTH*ADDR_WIDTH-1:0]  btb_target;
    logic                               redirect_valid;
    logic [ADDR_WIDTH-1:0]              redirect_pc;
    logic [DECODE_WIDTH-1:0]            dec_valid;
    logic [DECODE_WIDTH*DATA_WIDTH-1:0] dec_instr;
    logic [DECODE_WIDTH*ADDR_WIDTH-1:0] dec_pc;
    logic [DECODE_WIDTH-1:0]            dec_pred_taken;
    logic [DECODE_WIDTH*ADDR_WIDTH-1:0] dec_pred_target;
    logic                               dec_ready;
    logic [$clog2(FQ_DEPTH):0]          fq_count;

    modport master (
        output imem_addr, btb_pc, dec_valid, dec_instr, dec_pc,
               dec_pred_taken, dec_pred_target, fq_count,
        input  imem_data, btb_taken, btb_target, redirect_valid,
               redirect_pc, dec_ready
    );

    modport slave (
        input  imem_addr, btb_pc, dec_valid, dec_instr, dec_pc,
               dec_pred_taken, dec_pred_target, fq_count,
        output imem_data, btb_taken, btb_target, redirect_valid,
               redirect_pc, dec_ready
    );

endinterface

// File: rtl/fetch_unit_queue.sv
// Multi-write, multi-read circular FIFO; occupancy alone separates full from empty.
module fetch_queue #(
    parameter int ENTRY_W = 97,
    parameter int DEPTH   = 8,
    parameter int WR_W    = 2,
    parameter int RD_W    = 2,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1,
    localparam int NW     = $clog2(WR_W) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic [NW-1:0]           wr_cnt_i,
    input  logic [WR_W*ENTRY_W-1:0] wr_data_i,
    input  logic [NW-1:0]           rd_cnt_i,
    output logic [RD_W*ENTRY_W-1:0] rd_data_o,
    output logic [CW-1:0]           count_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;

    always_comb begin
        head_d  = head_q + PW'(rd_cnt_i);
        tail_d  = tail_q + PW'(wr_cnt_i);
        count_d = count_q + CW'(wr_cnt_i) - CW'(rd_cnt_i);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only occupancy decides what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_W; i++) begin
            if (NW'(i) < wr_cnt_i)
                mem_q[tail_q + PW'(i)] <= wr_data_i[i*ENTRY_W +: ENTRY_W];
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < RD_W; k++)
            rd_data_o[k*ENTRY_W +: ENTRY_W] = mem_q[head_q + PW'(k)];
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, taken-branch group truncation and next-PC, queue handshake gating.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FETCH_WIDTH  = DEF_FETCH_WIDTH,
    parameter int DECODE_WIDTH = DEF_DECODE_WIDTH,
    parameter int FQ_DEPTH     = DEF_FQ_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = DEF_RESET_PC
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.master bus
);

    localparam int LW = $clog2(FETCH_WIDTH) + 1;
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int EW = entry_width(ADDR_WIDTH, DATA_WIDTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  pred_taken;
        logic [ADDR_WIDTH-1:0] pred_target;
    } entry_t;

    logic [ADDR_WIDTH-1:0]        pc_q, pc_d, pc_seq, hit_tgt;
    logic [LW-1:0]                grp_len, n_avail, wr_cnt, rd_cnt;
    logic                         hit, space_ok, enq_ok, deq;
    logic [CW-1:0]                count;
    logic [FETCH_WIDTH*EW-1:0]    wr_data;
    logic [DECODE_WIDTH*EW-1:0]   rd_data;
    entry_t                       head_e [DECODE_WIDTH];

    // Group ends at the first predicted-taken slot; its target steers the next fetch.
    always_comb begin
        grp_len = LW'(FETCH_WIDTH);
        hit     = 1'b0;
        hit_tgt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (!hit && bus.btb_taken[i]) begin
                hit     = 1'b1;
                grp_len = LW'(i + 1);
                hit_tgt = bus.btb_target[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        pc_seq = pc_q + ADDR_WIDTH'({grp_len, 2'b00});
    end

    // Space check uses pre-dequeue occupancy, so a full queue never bypasses.
    assign space_ok = (CW'(FQ_DEPTH) - count) >= CW'(FETCH_WIDTH);
    assign enq_ok   = !bus.redirect_valid && space_ok;
    assign n_avail  = (count < CW'(DECODE_WIDTH)) ? LW'(count) : LW'(DECODE_WIDTH);
    assign deq      = bus.dec_ready && (n_avail != '0) && !bus.redirect_valid;
    assign wr_cnt   = enq_ok ? grp_len : '0;
    assign rd_cnt   = deq ? n_avail : '0;

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            wr_data[i*EW +: EW] = {bus.imem_data[i*DATA_WIDTH +: DATA_WIDTH],
                                   pc_q + ADDR_WIDTH'(4 * i),
                                   bus.btb_taken[i],
                                   bus.btb_target[i*ADDR_WIDTH +: ADDR_WIDTH]};
    end

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid)
            pc_d = bus.redirect_pc;
        else if (enq_ok)
            pc_d = hit ? hit_tgt : pc_seq;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    fetch_queue #(
        .ENTRY_W (EW),
        .DEPTH   (FQ_DEPTH),
        .WR_W    (FETCH_WIDTH),
        .RD_W    (DECODE_WIDTH)
    ) u_fq (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (bus.redirect_valid),
        .wr_cnt_i  (wr_cnt),
        .wr_data_i (wr_data),
        .rd_cnt_i  (rd_cnt),
        .rd_data_o (rd_data),
        .count_o   (count)
    );

    always_comb begin
        bus.dec_valid       = '0;
        bus.dec_instr       = '0;
        bus.dec_pc          = '0;
        bus.dec_pred_taken  = '0;
        bus.dec_pred_target = '0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            head_e[k] = entry_t'(rd_data[k*EW +: EW]);
            bus.dec_valid[k] = (LW'(k) < n_avail) && !bus.redirect_valid && !rst;
            bus.dec_instr[k*DATA_WIDTH +: DATA_WIDTH]       = head_e[k].instr;
            bus.dec_pc[k*ADDR_WIDTH +: ADDR_WIDTH]          = head_e[k].pc;
            bus.dec_pred_taken[k]                           = head_e[k].pred_taken;
            bus.dec_pred_target[k*ADDR_WIDTH +: ADDR_WIDTH] = head_e[k].pred_target;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.btb_pc    = pc_q;
    assign bus.fq_count  = rst ? '0 : count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with FETCH_WIDTH=2, DECODE_WIDTH=2, FQ_DEPTH=8.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FETCH_WIDTH(2), .DECODE_WIDTH(2), .FQ_DEPTH(8)
    ) bus ();

    fetch_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FETCH_WIDTH(2), .DECODE_WIDTH(2),
        .FQ_DEPTH(8), .RESET_PC(32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign bus.imem_data = {ins(bus.imem_addr + 32'd4), ins(bus.imem_addr)};

    typedef struct {
        logic [1:0]  taken;
        logic [31:0] tg0, tg1;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] e_addr;
        logic [3:0]  e_cnt;
        logic [1:0]  e_vld;
        logic [31:0] e_pc0, e_pc1;
        logic [1:0]  e_pt;
        logic [31:0] e_tg0, e_tg1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] tk, input logic [31:0] t0, input logic [31:0] t1,
                         input logic rv, input logic [31:0] rp, input logic rd);
        bus.btb_taken      = tk;
        bus.btb_target     = {t1, t0};
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.dec_ready      = rd;
    endtask

    initial begin
        // taken tg0 tg1 redir rpc rdy | addr cnt vld pc0 pc1 pt tg0 tg1
        vecs.push_back('{2'b00, 0, 0, 0, 0, 1, 32'h0,   0, 2'b00, 0, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 1, 32'h8,   2, 2'b11, 32'h0, 32'h4, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 1, 32'h10,  2, 2'b11, 32'h8, 32'hC, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 1, 32'h10, 1, 32'h18, 2, 2'b00, 0, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b01, 32'h40, 0, 0, 0, 1, 32'h10, 0, 2'b00, 0, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 0, 32'h40,  1, 2'b01, 32'h10, 0, 2'b01, 32'h40, 0});
        vecs.push_back('{2'b00, 0, 0, 1, 32'h10, 0, 32'h48, 3, 2'b00, 0, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b10, 0, 32'h80, 0, 0, 0, 32'h10, 0, 2'b00, 0, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 0, 32'h80,  2, 2'b11, 32'h10, 32'h14, 2'b10, 0, 32'h80});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 0, 32'h88,  4, 2'b11, 32'h10, 32'h14, 2'b10, 0, 32'h80});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 0, 32'h90,  6, 2'b11, 32'h10, 32'h14, 2'b10, 0, 32'h80});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 0, 32'h98,  8, 2'b11, 32'h10, 32'h14, 2'b10, 0, 32'h80});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 0, 32'h98,  8, 2'b11, 32'h10, 32'h14, 2'b10, 0, 32'h80});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 1, 32'h98,  8, 2'b11, 32'h10, 32'h14, 2'b10, 0, 32'h80});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 1, 32'h98,  6, 2'b11, 32'h80, 32'h84, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 1, 32'h200, 1, 32'hA0, 6, 2'b00, 0, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 1, 32'h200, 0, 2'b00, 0, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 1, 32'h208, 2, 2'b11, 32'h200, 32'h204, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 1, 32'h210, 2, 2'b11, 32'h208, 32'h20C, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 1, 32'hFFFF_FFF8, 1, 32'h218, 2, 2'b00, 0, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 2'b00, 0, 0, 2'b00, 0, 0});
        vecs.push_back('{2'b00, 0, 0, 0, 0, 1, 32'h0, 2, 2'b11, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 2'b00, 0, 0});

        rst = 1'b1;
        drive(2'b00, 0, 0, 1'b0, 0, 1'b1);
        cyc();
        cyc();
        chk("reset dec_valid", 64'(bus.dec_valid), 64'h0);
        chk("reset fq_count", 64'(bus.fq_count), 64'h0);
        rst = 1'b0;
        #1;
        chk("post-reset imem_addr", 64'(bus.imem_addr), 64'h0);
        chk("post-reset btb_pc", 64'(bus.btb_pc), 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].taken, vecs[i].tg0, vecs[i].tg1, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            #1;
            chk($sformatf("r%0d imem_addr", i), 64'(bus.imem_addr), 64'(vecs[i].e_addr));
            chk($sformatf("r%0d fq_count", i), 64'(bus.fq_count), 64'(vecs[i].e_cnt));
            chk($sformatf("r%0d dec_valid", i), 64'(bus.dec_valid), 64'(vecs[i].e_vld));
            if (vecs[i].e_vld[0]) begin
                chk($sformatf("r%0d dec_pc0", i), 64'(bus.dec_pc[31:0]), 64'(vecs[i].e_pc0));
                chk($sformatf("r%0d dec_instr0", i), 64'(bus.dec_instr[31:0]), 64'(ins(vecs[i].e_pc0)));
                chk($sformatf("r%0d pred_taken0", i), 64'(bus.dec_pred_taken[0]), 64'(vecs[i].e_pt[0]));
                if (vecs[i].e_pt[0])
                    chk($sformatf("r%0d pred_target0", i), 64'(bus.dec_pred_target[31:0]), 64'(vecs[i].e_tg0));
            end
            if (vecs[i].e_vld[1]) begin
                chk($sformatf("r%0d dec_pc1", i), 64'(bus.dec_pc[63:32]), 64'(vecs[i].e_pc1));
                chk($sformatf("r%0d dec_instr1", i), 64'(bus.dec_instr[63:32]), 64'(ins(vecs[i].e_pc1)));
                chk($sformatf("r%0d pred_taken1", i), 64'(bus.dec_pred_taken[1]), 64'(vecs[i].e_pt[1]));
                if (vecs[i].e_pt[1])
                    chk($sformatf("r%0d pred_target1", i), 64'(bus.dec_pred_target[63:32]), 64'(vecs[i].e_tg1));
            end
            cyc();
        end

        // Fill to full with decode stalled, then reset together with a redirect.
        drive(2'b00, 0, 0, 1'b0, 0, 1'b0);
        for (int j = 0; j < 4; j++) cyc();
        #1;
        chk("fill fq_count", 64'(bus.fq_count), 64'd8);
        chk("fill imem_addr", 64'(bus.imem_addr), 64'h20);
        rst = 1'b1;
        drive(2'b00, 0, 0, 1'b1, 32'h300, 1'b1);
        #1;
        chk("in-reset dec_valid", 64'(bus.dec_valid), 64'h0);
        chk("in-reset fq_count", 64'(bus.fq_count), 64'h0);
        cyc();
        rst = 1'b0;
        drive(2'b00, 0, 0, 1'b0, 0, 1'b1);
        #1;
        chk("after-reset imem_addr", 64'(bus.imem_addr), 64'h0);
        chk("after-reset fq_count", 64'(bus.fq_count), 64'h0);
        chk("after-reset dec_valid", 64'(bus.dec_valid), 64'h0);
        cyc();
        chk("restart fq_count", 64'(bus.fq_count), 64'd2);
        chk("restart imem_addr", 64'(bus.imem_addr), 64'h8);
        chk("restart dec_valid", 64'(bus.dec_valid), 64'h3);
        chk("restart dec_pc0", 64'(bus.dec_pc[31:0]), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
